fetch_unit: RTL and testbench
=============================

# fetch_unit

Stage-1 instruction fetch. Holds the PC and issues in-order word requests to instruction memory over a valid/ready request channel. It buffers returned instructions with their PCs and presents them to the decode stage (register-file read side) on a valid/ready handshake. A redirect from execute flushes buffered and in-flight fetches and restarts at the new PC.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- DEPTH, 2: buffer entries and maximum in-flight requests; power of two, at least 2.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request address valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response word valid; strictly in request order; latency 1 or more cycles
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken, from execute
- redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 0
- fd_valid  out  1  fd_pc/fd_instr hold a valid instruction
- fd_ready  in  1  decode consumes this cycle
- fd_pc  out  32  PC of the presented instruction
- fd_instr  out  32  presented instruction word

## Operation
- State:
  - pc register.
  - DEPTH-entry circular buffer; each entry holds {pc, instr, filled}, with head/tail pointers and used count.
  - drop_cnt, width clog2(DEPTH)+1: stale responses still to discard.
- Issue:
  - imem_req_valid = (used + drop_cnt < DEPTH) && !redirect_valid.
  - imem_req_addr = pc.
  - On accept (valid && ready): allocate entry at tail with pc and filled=0; pc <= pc + 4, wrapping modulo 2^32.
- Response:
  - If drop_cnt != 0: discard the word and decrement drop_cnt.
  - Otherwise: write instr into the oldest unfilled entry and set filled=1.
  - imem_rsp_valid with no outstanding request is a protocol error; assert in simulation.
- Output:
  - fd_valid = head entry filled; fd_pc and fd_instr come from the head entry.
  - On fd_valid && fd_ready: pop head.
  - Zero-valued fd_pc/fd_instr when fd_valid=0.
- Redirect, in the cycle redirect_valid=1:
  - Clear buffer: used=0, head=tail.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - drop_cnt <= drop_cnt + (allocated unfilled entries) − (1 if a response arrives this cycle).
  - No request is issued and no pop occurs; fd_ready that cycle is ignored.
- Simultaneous events:
  - Accept, fill and pop may all occur in one cycle; used changes by +1, 0, or −1 accordingly.
  - Redirect overrides all of them.
- Reset (async):
  - pc=RESET_PC, used=0, drop_cnt=0.
  - Outputs: imem_req_valid=0 while rst_n=0; imem_req_addr=RESET_PC; fd_valid=0; fd_pc=0; fd_instr=0.
  - Responses for requests issued before reset are the memory's responsibility to cancel.

## Timing
- Request: combinational from registered state plus redirect_valid; no combinational path from imem_rsp_* to imem_req_valid.
- Fill latency: response in cycle M gives fd_valid=1 in cycle M+1 at the earliest.
- Redirect latency: redirect in cycle N, first request for redirect_pc in cycle N+1. With memory latency L, the first fd_valid for that PC is in cycle N+2+L.
- Throughput: one instruction per cycle sustained when L=1, imem_req_ready=1 and fd_ready=1. DEPTH bounds both outstanding requests and buffering, so the unit never overflows.
- Full buffer: imem_req_valid=0 until a pop frees an entry. The freed entry is reissuable in the same cycle as the pop, because the count is taken after the pop.
- Buffer wrap-around: head/tail wrap modulo DEPTH.

## Structure
- The shared pipeline package holds typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}, constant INSTR_BYTES=4, and constant NOP_INSTR=32'h0000_0013 (used downstream for bubbles).
- One sub-module, fetch_buffer: circular buffer with alloc, fill-oldest-unfilled, pop and flush ports, and used/head_filled outputs. The fetch_unit top holds pc, drop_cnt and issue logic.

## Test plan
- Reset then stream:
  - Stimulus: memory L=1, always ready, fd_ready=1.
  - Required: requests 0x0, 0x4, 0x8, …; fd_valid from cycle 3 after reset release, one instruction per cycle, fd_pc matching.
- Backpressure:
  - Stimulus: fd_ready=0.
  - Required: exactly DEPTH=2 requests issue, then imem_req_valid=0.
  - Stimulus: release fd_ready.
  - Required: in-order delivery of 0x0, 0x4, 0x8 with no loss or duplication.
- Redirect with in-flight requests:
  - Stimulus: L=3, two requests outstanding, redirect to 0x100.
  - Required: the two stale responses are dropped; the next request is 0x100; first fd_pc=0x100.
- Redirect colliding with a response:
  - Stimulus: redirect and imem_rsp_valid in the same cycle, one other request outstanding.
  - Required: drop_cnt=1; only the 0x200 stream reaches decode.
- Edge cases:
  - Stimulus: redirect_pc=0xFFFF_FFFE.
  - Required: fetch starts at 0xFFFF_FFFC, then wraps to 0x0000_0000.
  - Stimulus: async reset asserted mid-stream.
  - Required: all outputs return to reset values immediately, with no clock needed.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared pipeline types and constants for the fetch stage.
// Imported by the fetch unit and its buffer.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular fetch buffer: allocate at tail, fill oldest unfilled,
// pop at head, flush on redirect.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_instr,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] used,
  output logic [CW-1:0] unfilled,
  output logic          head_filled,
  output fetch_entry_t  head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   ent [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW-1:0]  head_q;
  logic [AW-1:0]  tail_q;
  logic [CW-1:0]  used_q;
  logic [CW-1:0]  nfill_q;
  logic [AW-1:0]  fill_idx;

  // Fills land in order, so filled entries form a prefix from head.
  assign fill_idx    = head_q + nfill_q[AW-1:0];
  assign used        = used_q;
  assign unfilled    = used_q - nfill_q;
  assign head_filled = filled_q[head_q];
  assign head        = ent[head_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      used_q   <= '0;
      nfill_q  <= '0;
      filled_q <= '0;
    end else if (flush) begin
      head_q   <= tail_q;
      used_q   <= '0;
      nfill_q  <= '0;
      filled_q <= '0;
    end else begin
      if (alloc) begin
        tail_q           <= tail_q + AW'(1);
        filled_q[tail_q] <= 1'b0;
      end
      if (pop) begin
        head_q           <= head_q + AW'(1);
        filled_q[head_q] <= 1'b0;
      end
      if (fill) begin
        filled_q[fill_idx] <= 1'b1;
      end
      used_q  <= used_q + CW'(alloc) - CW'(pop);
      nfill_q <= nfill_q + CW'(fill) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && alloc) begin
      ent[tail_q].pc <= alloc_pc;
    end
    if (!flush && fill) begin
      ent[fill_idx].instr <= fill_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Stage-1 fetch: PC, in-order imem requests, stale-response
// dropping after redirect, and the fetch/decode handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] used;
  logic [CW-1:0] unfilled;
  logic          head_filled;
  fetch_entry_t  head;
  logic          pop;
  logic          accept;
  logic          fill;
  logic [CW-1:0] used_nx;
  logic [CW:0]   occ;

  assign pop     = head_filled && fd_ready && !redirect_valid;
  // Room is judged after this cycle's pop so a freed slot reissues at once.
  assign used_nx = used - CW'(pop);
  assign occ     = {1'b0, used_nx} + {1'b0, drop_q};

  assign imem_req_valid = rst_n && !redirect_valid && (occ < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign fill = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign fd_valid = head_filled;
  assign fd_pc    = head_filled ? head.pc : '0;
  assign fd_instr = head_filled ? head.instr : '0;

  fetch_buffer #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc       (accept),
    .alloc_pc    (pc_q),
    .fill        (fill),
    .fill_instr  (imem_rsp_data),
    .pop         (pop),
    .flush       (redirect_valid),
    .used        (used),
    .unfilled    (unfilled),
    .head_filled (head_filled),
    .head        (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc & ~32'h3;
      drop_q <= drop_q + unfilled - CW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        pc_q <= pc_q + 32'(INSTR_BYTES);
      end
      if (imem_rsp_valid && drop_q != '0) begin
        drop_q <= drop_q - CW'(1);
      end
    end
  end

  a_rsp_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (drop_q != '0 || unfilled != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable
// in-order instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fd_valid       (fd_valid),
    .fd_ready       (fd_ready),
    .fd_pc          (fd_pc),
    .fd_instr       (fd_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int compared   = 0;
  int mismatched = 0;
  int lat        = 1;
  int cyc_no     = 0;

  mreq_t       mq [$];
  logic [31:0] req_log [$];
  logic [31:0] rx_pc [$];
  logic [31:0] rx_in [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rxp_at(input int i);
    return (i < rx_pc.size()) ? rx_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rxi_at(input int i);
    return (i < rx_in.size()) ? rx_in[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set; advances one cycle.
  task automatic cyc();
    if (mq.size() > 0 && mq[0].due <= cyc_no) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc_no + lat});
      req_log.push_back(imem_req_addr);
    end
    if (fd_valid && fd_ready && !redirect_valid) begin
      rx_pc.push_back(fd_pc);
      rx_in.push_back(fd_instr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic restart(input int l);
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    mq.delete();
    req_log.delete();
    rx_pc.delete();
    rx_in.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    cyc_no = 1;
    lat    = l;
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fd_ready       = 1'b1;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_fd_valid", fd_valid, 0);
    check("rst_fd_pc", fd_pc, 0);
    check("rst_fd_instr", fd_instr, 0);

    // Streaming with L=1
    restart(1);
    check("s_c1_req_valid", imem_req_valid, 1);
    check("s_c1_addr", imem_req_addr, 32'h0);
    check("s_c1_fd_valid", fd_valid, 0);
    cyc();
    check("s_c2_addr", imem_req_addr, 32'h4);
    check("s_c2_fd_valid", fd_valid, 0);
    cyc();
    for (int k = 0; k < 6; k++) begin
      check("s_fd_valid", fd_valid, 1);
      check("s_fd_pc", fd_pc, 32'(4 * k));
      check("s_fd_instr", fd_instr, mem_word(32'(4 * k)));
      check("s_req_addr", imem_req_addr, 32'(4 * (k + 2)));
      cyc();
    end

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("ar_req_valid", imem_req_valid, 0);
    check("ar_req_addr", imem_req_addr, 0);
    check("ar_fd_valid", fd_valid, 0);
    check("ar_fd_pc", fd_pc, 0);
    check("ar_fd_instr", fd_instr, 0);

    // Backpressure
    fd_ready = 1'b0;
    restart(1);
    repeat (5) cyc();
    check("bp_req_count", 32'(req_log.size()), 2);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_fd_valid", fd_valid, 1);
    check("bp_fd_pc", fd_pc, 32'h0);
    fd_ready = 1'b1;
    repeat (6) cyc();
    check("bp_rx0", rxp_at(0), 32'h0);
    check("bp_rx1", rxp_at(1), 32'h4);
    check("bp_rx2", rxp_at(2), 32'h8);
    check("bp_rx1_instr", rxi_at(1), mem_word(32'h4));

    // Redirect with two requests in flight, L=3
    restart(3);
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("rd_req_valid", imem_req_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    check("rd_drop_cnt", 32'(dut.drop_q), 2);
    req_log.delete();
    rx_pc.delete();
    rx_in.delete();
    repeat (12) cyc();
    check("rd_first_req", req_at(0), 32'h100);
    check("rd_rx0", rxp_at(0), 32'h100);
    check("rd_rx0_instr", rxi_at(0), mem_word(32'h100));
    check("rd_rx1", rxp_at(1), 32'h104);

    // Redirect colliding with a response, L=2
    restart(2);
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("co_req_valid", imem_req_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("co_drop_cnt", 32'(dut.drop_q), 1);
    check("co_req_valid_n1", imem_req_valid, 1);
    check("co_req_addr_n1", imem_req_addr, 32'h200);
    req_log.delete();
    rx_pc.delete();
    rx_in.delete();
    cyc();
    cyc();
    check("co_fd_valid_early", fd_valid, 0);
    cyc();
    check("co_fd_valid", fd_valid, 1);
    check("co_fd_pc", fd_pc, 32'h200);
    repeat (4) cyc();
    check("co_rx0", rxp_at(0), 32'h200);
    check("co_rx1", rxp_at(1), 32'h204);

    // Unaligned redirect near the top of memory, then wrap
    restart(1);
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    #1;
    cyc();
    redirect_valid = 1'b0;
    req_log.delete();
    rx_pc.delete();
    rx_in.delete();
    repeat (8) cyc();
    check("wr_req0", req_at(0), 32'hFFFF_FFFC);
    check("wr_req1", req_at(1), 32'h0000_0000);
    check("wr_rx0", rxp_at(0), 32'hFFFF_FFFC);
    check("wr_rx1", rxp_at(1), 32'h0000_0000);
    check("wr_rx1_instr", rxi_at(1), mem_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
